// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the arbiter FSM state encoding, the transmitter data width and the
// frame length the transmitter starts with after reset.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    // Frame length presented to the transmitter while no frame has been granted.
    localparam logic [7:0] DEFAULT_NBITS = 8'd8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WAIT_CLR  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Chooses the first set request at or after ptr, wrapping modulo N_REQ.
// Ports:
//   req   in   N_REQ  request levels
//   ptr   in   IDX_W  highest-priority index for this pick
//   gnt   out  N_REQ  one-hot winner (all-zero when no request)
//   idx   out  IDX_W  index of the winner
//   valid out  1      at least one request is set
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic             hi_valid;
    logic [IDX_W-1:0] hi_idx;
    logic             lo_valid;
    logic [IDX_W-1:0] lo_idx;

    // Scanning downward leaves the lowest matching index in each candidate.
    // hi_* only considers indices >= ptr; lo_* is the wrapped fallback.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_valid = 1'b0;
        lo_idx   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_valid = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_valid = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        valid = lo_valid;
        idx   = hi_valid ? hi_idx : lo_idx;
        for (int i = 0; i < int'(N_REQ); i++) begin
            gnt[i] = valid && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ requesters.
// A granted byte is presented on TxData, TxEn is held for LAUNCH_CYC cycles,
// then the FSM waits for the synchronised TxDone, acknowledges the requester
// and waits for TxDone to clear before the next grant.
// Optional build macro UART_TX_ARB_TIMEOUT_EN adds a TxDone watchdog and the
// TimeoutErr output.
// Ports:
//   Clk, Rst_n  clock, asynchronous active-low reset
//   Req         per-requester request level, held until Ack
//   ReqData     requester i byte at [i*DATA_W +: DATA_W]
//   CfgNBits    frame length, sampled at grant
//   Ack         one-cycle pulse to the served requester
//   Grant       one-hot current owner, zero in IDLE
//   TxEn        transmitter enable
//   TxData      latched byte to the transmitter
//   NBits       latched frame length
//   TxDone      transmitter done level (other clock domain)
//   TimeoutErr  watchdog expiry pulse (only with UART_TX_ARB_TIMEOUT_EN)
//   Busy        high outside IDLE
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned LAUNCH_CYC = 3,
    parameter int unsigned TIMEOUT_W  = 20
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] ReqData,
    input  logic [7:0]              CfgNBits,
    output logic [N_REQ-1:0]        Ack,
    output logic [N_REQ-1:0]        Grant,
    output logic                    TxEn,
    output logic [DATA_W-1:0]       TxData,
    output logic [7:0]              NBits,
    input  logic                    TxDone,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic                    TimeoutErr,
`endif
    output logic                    Busy
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned LCNT_W = $clog2(LAUNCH_CYC);

    if (N_REQ < 2 || N_REQ > 8 || DATA_W != UART_DATA_W || LAUNCH_CYC < 2 ||
        TIMEOUT_W < 2) begin : g_bad_params
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [7:0]        nbits_q, nbits_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              tx_en_q, busy_q;
    logic              done_meta_q, done_s;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]  next_ptr;

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Firing on the edge that would make the counter all-ones puts the pulse
    // 2^TIMEOUT_W-1 cycles after WAIT_DONE entry.
    localparam logic [TIMEOUT_W-1:0] TO_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (Req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_gnt[i]) begin
                sel_data = ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        ack_d     = '0;
        tx_data_d = tx_data_q;
        nbits_d   = nbits_q;
        lcnt_d    = lcnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A lingering done_s means the transmitter has not re-armed yet.
                if (arb_valid && !done_s) begin
                    idx_d     = arb_idx;
                    grant_d   = arb_gnt;
                    tx_data_d = sel_data;
                    nbits_d   = CfgNBits;
                    lcnt_d    = '0;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (lcnt_q == LCNT_W'(LAUNCH_CYC - 1)) begin
                    state_d = ST_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (done_s) begin
                    ack_d   = grant_q;
                    ptr_d   = next_ptr;
                    state_d = ST_WAIT_CLR;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_FIRE) begin
                    timeout_d = 1'b1;
                    ack_d     = grant_q;
                    ptr_d     = next_ptr;
                    grant_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
                end
`endif
            end
            ST_WAIT_CLR: begin
                if (!done_s) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            tx_data_q   <= '0;
            nbits_q     <= DEFAULT_NBITS;
            lcnt_q      <= '0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_meta_q <= 1'b0;
            done_s      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            tx_data_q   <= tx_data_d;
            nbits_q     <= nbits_d;
            lcnt_q      <= lcnt_d;
            // Registered from next state so TxEn is glitch-free for the
            // transmitter's edge detector.
            tx_en_q     <= (state_d == ST_LAUNCH);
            busy_q      <= (state_d != ST_IDLE);
            done_meta_q <= TxDone;
            done_s      <= done_meta_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign Ack    = ack_q;
    assign Grant  = grant_q;
    assign TxEn   = tx_en_q;
    assign TxData = tx_data_q;
    assign NBits  = nbits_q;
    assign Busy   = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign TimeoutErr = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, LAUNCH_CYC=3).
// Table rows describe one full frame each; reset mid-frame and the optional
// watchdog are hand-written sequences.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW       = 6;
    localparam int LONG_DLY = 40;
`else
    localparam int TW       = 20;
    localparam int LONG_DLY = 200;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [3:0]  Req;
    logic [31:0] ReqData;
    logic [7:0]  CfgNBits;
    logic [3:0]  Ack;
    logic [3:0]  Grant;
    logic        TxEn;
    logic [7:0]  TxData;
    logic [7:0]  NBits;
    logic        TxDone;
    logic        Busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic        TimeoutErr;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(
        .N_REQ      (4),
        .DATA_W     (8),
        .LAUNCH_CYC (3),
        .TIMEOUT_W  (TW)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req        (Req),
        .ReqData    (ReqData),
        .CfgNBits   (CfgNBits),
        .Ack        (Ack),
        .Grant      (Grant),
        .TxEn       (TxEn),
        .TxData     (TxData),
        .NBits      (NBits),
        .TxDone     (TxDone),
`ifdef UART_TX_ARB_TIMEOUT_EN
        .TimeoutErr (TimeoutErr),
`endif
        .Busy       (Busy)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  cfg;
        int          idx;
        logic [7:0]  xdata;
        logic [7:0]  xnb;
        int          delay;    // cycles between TxEn falling and TxDone rising
        int          hold;     // extra cycles TxDone stays high after Ack
        logic [3:0]  ack_req;  // Req value driven once Ack is seen
        bit          mutate;   // scramble ReqData/CfgNBits and drop Req after grant
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(Grant), 32'h0);
        chk({tag, "_ack"}, 32'(Ack), 32'h0);
        chk({tag, "_txen"}, 32'(TxEn), 32'h0);
        chk({tag, "_txdata"}, 32'(TxData), 32'h0);
        chk({tag, "_nbits"}, 32'(NBits), 32'd8);
        chk({tag, "_busy"}, 32'(Busy), 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        int n;
        int bad;
        oh = 4'(1 << v.idx);
        Req = v.req;
        ReqData = v.data;
        CfgNBits = v.cfg;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Grant == 4'h0 && n < 20);
        chk("grant", 32'(Grant), 32'(oh));
        chk("txdata", 32'(TxData), 32'(v.xdata));
        chk("nbits", 32'(NBits), 32'(v.xnb));
        chk("busy_on_grant", 32'(Busy), 32'h1);
        if (v.mutate) begin
            ReqData = ~v.data;
            CfgNBits = 8'd7;
            Req = v.ack_req;
        end
        n = 0;
        while (TxEn === 1'b1 && n < 10) begin
            n++;
            @(negedge Clk);
        end
        chk("txen_cycles", 32'(n), 32'd3);
        bad = 0;
        repeat (v.delay) begin
            @(negedge Clk);
            if (Ack != 4'h0 || TxEn !== 1'b0 || Grant != oh) bad++;
        end
        chk("wait_done_quiet", 32'(bad), 32'd0);
        TxDone = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Ack == 4'h0 && n < 20);
        chk("ack", 32'(Ack), 32'(oh));
        chk("ack_latency", 32'(n), 32'd3);
        Req = v.ack_req;
        @(negedge Clk);
        chk("ack_one_cycle", 32'(Ack), 32'h0);
        bad = 0;
        repeat (v.hold) begin
            @(negedge Clk);
            if (Grant != oh || Busy !== 1'b1 || TxEn !== 1'b0 || Ack != 4'h0) bad++;
        end
        chk("no_grant_while_done", 32'(bad), 32'd0);
        if (v.mutate) begin
            chk("txdata_held", 32'(TxData), 32'(v.xdata));
            chk("nbits_held", 32'(NBits), 32'(v.xnb));
        end
        TxDone = 1'b0;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Busy !== 1'b0 && n < 20);
        chk("busy_low", 32'(Busy), 32'h0);
        chk("grant_cleared", 32'(Grant), 32'h0);
    endtask

    initial begin
        int n;
        int bad;

        //          req      data          cfg  idx xdata  xnb  delay     hold ack_req mut
        vecs[0]  = '{4'b1111, 32'h44332211, 8'd8, 0, 8'h11, 8'd8, 5,        2,  4'b1111, 1'b0};
        vecs[1]  = '{4'b1111, 32'h44332211, 8'd8, 1, 8'h22, 8'd8, 5,        2,  4'b1111, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211, 8'd8, 2, 8'h33, 8'd8, 5,        2,  4'b1111, 1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211, 8'd8, 3, 8'h44, 8'd8, 5,        2,  4'b1111, 1'b0};
        vecs[4]  = '{4'b1111, 32'h44332211, 8'd8, 0, 8'h11, 8'd8, 5,        2,  4'b0000, 1'b0};
        vecs[5]  = '{4'b0001, 32'h000000A5, 8'd8, 0, 8'hA5, 8'd8, LONG_DLY, 2,  4'b0000, 1'b0};
        vecs[6]  = '{4'b0001, 32'h0000005A, 8'd5, 0, 8'h5A, 8'd5, 3,        1,  4'b0000, 1'b0};
        vecs[7]  = '{4'b1010, 32'hB000C000, 8'd6, 1, 8'hC0, 8'd6, 4,        2,  4'b1000, 1'b0};
        vecs[8]  = '{4'b1010, 32'hB000C000, 8'd6, 3, 8'hB0, 8'd6, 4,        2,  4'b0000, 1'b0};
        vecs[9]  = '{4'b0100, 32'h00770000, 8'd7, 2, 8'h77, 8'd7, 6,        2,  4'b0000, 1'b0};
        vecs[10] = '{4'b0100, 32'h003C0000, 8'd8, 2, 8'h3C, 8'd8, 10,       3,  4'b0000, 1'b1};
        vecs[11] = '{4'b0011, 32'h00006655, 8'd8, 0, 8'h55, 8'd8, 5,        50, 4'b0010, 1'b0};
        vecs[12] = '{4'b0010, 32'h00006655, 8'd8, 1, 8'h66, 8'd8, 5,        2,  4'b0000, 1'b0};
        vecs[13] = '{4'b0110, 32'h00BBAA00, 8'd8, 1, 8'hAA, 8'd8, 5,        2,  4'b0000, 1'b0};

        Rst_n = 1'b0;
        Req = 4'h0;
        ReqData = 32'h0;
        CfgNBits = 8'd8;
        TxDone = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Rst_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while waiting for TxDone: everything drops, no Ack, ptr back to 0.
        Req = 4'b1000;
        ReqData = 32'hD1000000;
        CfgNBits = 8'd6;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Grant == 4'h0 && n < 20);
        chk("rst_seq_grant", 32'(Grant), 32'h8);
        n = 0;
        while (TxEn === 1'b1 && n < 10) begin
            n++;
            @(negedge Clk);
        end
        repeat (5) @(negedge Clk);
        chk("rst_seq_busy_before", 32'(Busy), 32'h1);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        bad = 0;
        repeat (2) begin
            @(negedge Clk);
            if (Ack != 4'h0 || Grant != 4'h0 || TxEn !== 1'b0) bad++;
        end
        Rst_n = 1'b1;
        Req = 4'h0;
        repeat (3) begin
            @(negedge Clk);
            if (Ack != 4'h0 || Busy !== 1'b0) bad++;
        end
        chk("rst_no_ack", 32'(bad), 32'd0);
        run_vec(vecs[13]);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // TxDone never rises: watchdog fires 63 cycles after WAIT_DONE entry.
        Req = 4'b0001;
        ReqData = 32'h000000E1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Grant == 4'h0 && n < 20);
        chk("to_grant", 32'(Grant), 32'h1);
        n = 0;
        while (TxEn === 1'b1 && n < 10) begin
            n++;
            @(negedge Clk);
        end
        n = 0;
        while (TimeoutErr !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("to_latency", 32'(n), 32'd63);
        chk("to_ack", 32'(Ack), 32'h1);
        chk("to_idle", 32'(Busy), 32'h0);
        chk("to_grant_clr", 32'(Grant), 32'h0);
        Req = 4'h0;
        @(negedge Clk);
        chk("to_pulse", 32'(TimeoutErr), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_REQ byte-producing requesters using round-robin arbitration.
- Sequences the transmitter: presents the byte, raises TxEn long enough for its Clk-domain rising-edge detector, then waits for TxDone, which comes from the Tick domain.
- Returns a one-cycle acknowledge to the requester that was served.
- Sits between the command/telemetry sources and the single TX pin driver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; fixed to the transmitter data width.
- LAUNCH_CYC, 3, Clk cycles TxEn is held high per frame (>=2).
- TIMEOUT_W, 20, width of the TxDone watchdog counter (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- Req  in  N_REQ  per-requester level request; held until Ack.
- ReqData  in  N_REQ*DATA_W  requester i byte at bits [i*8+7:i*8]; stable while Req[i]=1.
- CfgNBits  in  8  data bits per frame; sampled at grant.
- Ack  out  N_REQ  one-cycle pulse to the served requester.
- Grant  out  N_REQ  one-hot; current owner, all-zero when IDLE.
- TxEn  out  1  transmitter enable.
- TxData  out  DATA_W  byte to the transmitter.
- NBits  out  8  frame length to the transmitter.
- TxDone  in  1  transmitter done level; asynchronous to Clk (Tick domain).
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - state=IDLE.
  - Grant=0, Ack=0, TxEn=0, TxData=0, NBits=8, Busy=0.
  - Round-robin pointer = 0; TxDone synchroniser flops = 0.
- TxDone passes through a 2-flop synchroniser; done_s is its output. Only done_s is used internally.
- State machine:
  - IDLE: if any Req, pick the first set Req index at or after ptr, wrapping modulo N_REQ.
    - Latch TxData=ReqData[idx], NBits=CfgNBits, Grant=onehot(idx).
    - Go to LAUNCH next cycle. Decision to TxEn high is 1 cycle.
  - LAUNCH: TxEn=1 for exactly LAUNCH_CYC cycles, then TxEn=0 and go to WAIT_DONE.
  - WAIT_DONE: wait for done_s=1.
    - Then pulse Ack[idx] for 1 cycle, set ptr=(idx+1) mod N_REQ, go to WAIT_CLR.
  - WAIT_CLR: wait for done_s=0 (the transmitter's TxDone clears on its next Tick after returning to IDLE).
    - Then Grant=0 and go to IDLE.
    - No new grant may be issued while done_s=1.
- Latching rules:
  - TxData and NBits are held constant from grant until IDLE is re-entered.
  - Changes on ReqData or CfgNBits during a frame have no effect.
- Req behaviour:
  - Req[idx] dropped during a frame: the frame completes and Ack still pulses.
  - Requester must deassert Req on the cycle after Ack. If Req is still high in IDLE, it is treated as a new request.
- Arbitration boundaries:
  - Simultaneous requests: strict round-robin; each requester is served at most once per N_REQ grants while others wait.
  - Single requester: back-to-back service is allowed.
  - Pointer wraps from N_REQ-1 to 0.
- done_s already 1 on entry to WAIT_DONE (stale): ignored. The FSM only advances on done_s observed in WAIT_DONE after LAUNCH completes; WAIT_CLR guarantees it was low beforehand.
- Reset mid-frame: all outputs return to reset values immediately; no Ack is issued. The transmitter re-arms on the next TxEn rising edge.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - Adds output TimeoutErr (1 bit, reset 0) and a TIMEOUT_W counter cleared on entry to WAIT_DONE.
  - If the counter saturates at all-ones before done_s: pulse TimeoutErr and Ack[idx] for 1 cycle, advance ptr, go to IDLE directly.
- Undefined: no counter and no TimeoutErr port; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants ST_IDLE, ST_LAUNCH, ST_WAIT_DONE, ST_WAIT_CLR.
  - UART_DATA_W=8.
  - Default NBits constant 8.
- Sub-module rr_arbiter: N_REQ-wide combinational round-robin pick from Req and ptr, giving a one-hot output plus an index. Reusable by the RX-side command mux.

Test Plan:
- Single request: Req=0001, ReqData[0]=8'hA5, CfgNBits=8, TxDone model asserts 200 cycles after TxEn -> TxData=A5, TxEn high 3 cycles, Ack[0] one pulse after done_s, Busy low after TxDone clears.
- Contention: Req=1111 held, bytes 11/22/33/44 -> grant order 0,1,2,3,0; four distinct frames; Ack in the same order.
- Data stability: change ReqData[2] and CfgNBits to 7 mid-frame -> TxData and NBits unchanged until IDLE.
- Stale done: hold TxDone=1 for 50 cycles after Ack -> no new grant until done_s=0; then Req[1] is granted next.
- Reset mid-WAIT_DONE: Rst_n low for 2 cycles -> Grant=0, TxEn=0, no Ack; the next request is served from ptr=0.
- With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_W=6, TxDone stuck at 0 -> TimeoutErr pulses 63 cycles after WAIT_DONE entry, Ack pulses, FSM returns to IDLE.
